// File: rtl/sync_up_cntr_pkg.sv
// Shared constants, the default count type and the width-to-maximum helper for sync_up_cntr.
package sync_up_cntr_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    // Uses a 64-bit result so that a 32-bit counter does not overflow the shift.
    function automatic longint unsigned max_for_width(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_up_cntr.sv
// Synchronous modulo-(MAX_VAL+1) up counter with enable, clear, terminal-count and wrap flags.
// Define SYNC_UP_CNTR_LOAD_EN to add the saturating parallel-load port pair (load, load_val).
module sync_up_cntr
    import sync_up_cntr_pkg::*;
#(
    parameter int              WIDTH   = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VAL = max_for_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
`ifdef SYNC_UP_CNTR_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 1 || WIDTH > 32 || MAX_VAL > max_for_width(WIDTH)) begin : g_bad_params
        $error("sync_up_cntr: WIDTH must be 1..32 and MAX_VAL must fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = MAX_VAL[WIDTH-1:0];

    logic at_max;

    // tc is gated by reset and clear because neither of those edges will produce a wrap.
    always_comb begin
        at_max = (count == MAX_COUNT);
        tc     = at_max && enable && reset && !clear;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end
`ifdef SYNC_UP_CNTR_LOAD_EN
        else if (load) begin
            count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val;
            wrap  <= 1'b0;
        end
`endif
        else if (enable) begin
            if (at_max) begin
                count <= '0;
                wrap  <= 1'b1;
            end else begin
                count <= count + 1'b1;
                wrap  <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    enable_known: assert property (@(posedge clk) reset |-> !$isunknown(enable))
        else $error("sync_up_cntr: enable is X/Z while out of reset");

endmodule

// File: tb/tb_sync_up_cntr.sv
// Self-checking bench for sync_up_cntr: a full-range instance (MAX_VAL=15) and a decade instance (MAX_VAL=9).
// Load checks run only when SYNC_UP_CNTR_LOAD_EN is defined.
module tb_sync_up_cntr;
    import sync_up_cntr_pkg::*;

    logic   clk;
    logic   reset;
    logic   enable;
    logic   clear;
`ifdef SYNC_UP_CNTR_LOAD_EN
    logic   load;
    count_t load_val;
`endif
    count_t count;
    logic   tc;
    logic   wrap;
    count_t count9;
    logic   tc9;
    logic   wrap9;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic   rst;
        logic   clr;
        logic   en;
        count_t exp_count;
        logic   exp_tc;
        logic   exp_wrap;
    } vec_t;

    vec_t vecs[10];

    sync_up_cntr #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
`ifdef SYNC_UP_CNTR_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    sync_up_cntr #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
`ifdef SYNC_UP_CNTR_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .count    (count9),
        .tc       (tc9),
        .wrap     (wrap9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives the control inputs, then returns 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic clr, input logic en);
        reset  = rst;
        clear  = clr;
        enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        reset  = 1'b0;
        clear  = 1'b0;
        enable = 1'b0;
`ifdef SYNC_UP_CNTR_LOAD_EN
        load     = 1'b0;
        load_val = '0;
`endif

        // rst, clr, en, count, tc, wrap (tc evaluated after the edge with the same inputs)
        vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].en);
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d tc", i),    32'(tc),    32'(vecs[i].exp_tc));
            checkOutput($sformatf("vec%0d wrap", i),  32'(wrap),  32'(vecs[i].exp_wrap));
        end

        // Continuous enable from 0: both moduli side by side across 25 edges.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clr16 count", 32'(count), 32'd0);
        checkOutput("clr10 count", 32'(count9), 32'd0);
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("run16[%0d] count", k), 32'(count), 32'(k % 16));
            checkOutput($sformatf("run16[%0d] wrap", k),  32'(wrap),  32'((k % 16) == 0));
            checkOutput($sformatf("run16[%0d] tc", k),    32'(tc),    32'((k % 16) == 15));
            checkOutput($sformatf("run10[%0d] count", k), 32'(count9), 32'(k % 10));
            checkOutput($sformatf("run10[%0d] wrap", k),  32'(wrap9),  32'((k % 10) == 0));
            checkOutput($sformatf("run10[%0d] tc", k),    32'(tc9),    32'((k % 10) == 9));
        end

        // Hold at 7 for five edges.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("hold start count", 32'(count), 32'd7);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("hold[%0d] count", k), 32'(count), 32'd7);
            checkOutput($sformatf("hold[%0d] tc", k),    32'(tc),    32'd0);
            checkOutput($sformatf("hold[%0d] wrap", k),  32'(wrap),  32'd0);
        end

        // Clear and reset override enable mid-count.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("pre-clear count", 32'(count), 32'd9);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear prio count", 32'(count), 32'd0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("pre-reset count", 32'(count), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("reset prio count", 32'(count), 32'd0);
        checkOutput("reset prio wrap", 32'(wrap), 32'd0);

        // tc gating at count 15, then the wrapping edge.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("gate count", 32'(count), 32'd15);
        clear = 1'b1;
        #1;
        checkOutput("tc gated by clear", 32'(tc), 32'd0);
        clear = 1'b0;
        #1;
        checkOutput("tc at max", 32'(tc), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("tc gated by reset", 32'(tc), 32'd0);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        checkOutput("tc gated by enable", 32'(tc), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("gate wrap count", 32'(count), 32'd0);
        checkOutput("gate wrap pulse", 32'(wrap), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("post wrap pulse", 32'(wrap), 32'd0);

`ifdef SYNC_UP_CNTR_LOAD_EN
        // Load beats enable; values above MAX_VAL saturate; clear beats load.
        applyStimulus(1'b1, 1'b1, 1'b1);
        load     = 1'b1;
        load_val = 4'd12;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("load16 count", 32'(count), 32'd12);
        checkOutput("load10 sat count", 32'(count9), 32'd9);
        load = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("after load16 count", 32'(count), 32'd13);
        checkOutput("after load10 count", 32'(count9), 32'd0);
        checkOutput("after load10 wrap", 32'(wrap9), 32'd1);
        load     = 1'b1;
        load_val = 4'd5;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("clear over load", 32'(count), 32'd0);
        load = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
